// File: rtl/reg_file_sb.sv
// Register file with scoreboard: NUM_RD combinational reads (optional write bypass), two write ports.
// Writes, claims and busy_cnt update on the rising edge; no backpressure, every request is accepted.
module reg_file_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1,
   parameter int V0_IDX = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr0_en,
   input  logic [ADDR_W-1:0]          wr0_addr,
   input  logic [DATA_W-1:0]          wr0_data,
   input  logic                       wr1_en,
   input  logic [ADDR_W-1:0]          wr1_addr,
   input  logic [DATA_W-1:0]          wr1_data,
   input  logic                       claim_en,
   input  logic [ADDR_W-1:0]          claim_addr,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   output logic [ADDR_W:0]            busy_cnt,
   output logic [DATA_W-1:0]          register_v0
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] V0_A = ADDR_W'(V0_IDX);

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic [ADDR_W:0]   cnt_nxt;
   logic              wr0_ok;
   logic              wr1_ok;
   logic              claim_ok;

   assign wr0_ok   = wr0_en   && (wr0_addr   != '0);
   assign wr1_ok   = wr1_en   && (wr1_addr   != '0);
   assign claim_ok = claim_en && (claim_addr != '0);

   // Claim is applied last so a new producer overrides a same-cycle writeback.
   always_comb begin
      busy_nxt = busy;
      if (wr0_ok)   busy_nxt[wr0_addr]   = 1'b0;
      if (wr1_ok)   busy_nxt[wr1_addr]   = 1'b0;
      if (claim_ok) busy_nxt[claim_addr] = 1'b1;
   end

   always_comb begin
      cnt_nxt = '0;
      for (int k = 0; k < DEPTH; k++) begin
         cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            regs[k] <= '0;
         end
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         if (wr0_ok) regs[wr0_addr] <= wr0_data;
         if (wr1_ok) regs[wr1_addr] <= wr1_data;
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

   assign register_v0 = regs[V0_A];

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              b;

      assign a = rd_addr[g*ADDR_W +: ADDR_W];

      always_comb begin
         d = regs[a];
         b = busy[a];
         if (BYPASS != 0) begin
            if (wr1_ok && (wr1_addr == a)) begin
               d = wr1_data;
               b = 1'b0;
            end else if (wr0_ok && (wr0_addr == a)) begin
               d = wr0_data;
               b = 1'b0;
            end
         end
         if (reset || (a == '0)) begin
            d = '0;
            b = 1'b0;
         end
      end

      assign rd_data[g*DATA_W +: DATA_W] = d;
      assign rd_busy[g]                  = b;
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: bypassing and non-bypassing instances share stimulus against one array model.
module tb_reg_file_sb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr0_en, wr1_en, claim_en;
   logic [AW-1:0] wr0_addr, wr1_addr, claim_addr;
   logic [DW-1:0] wr0_data, wr1_data;
   logic [AW-1:0] ra [NR];
   logic [NR*AW-1:0] rd_addr;

   logic [NR*DW-1:0] rd_data_a, rd_data_b;
   logic [NR-1:0]    rd_busy_a, rd_busy_b;
   logic [AW:0]      cnt_a, cnt_b;
   logic [DW-1:0]    v0_a, v0_b;

   logic [DW-1:0] m_reg  [32];
   bit            m_busy [32];
   int            n_cmp = 0;
   int            n_err = 0;

   always #5 clk = ~clk;
   assign rd_addr = {ra[1], ra[0]};

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .V0_IDX(2)) dut_byp (
      .clk(clk), .reset(reset),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .busy_cnt(cnt_a), .register_v0(v0_a)
   );

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .V0_IDX(2)) dut_nobyp (
      .clk(clk), .reset(reset),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .busy_cnt(cnt_b), .register_v0(v0_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   function automatic int pending();
      int n = 0;
      for (int k = 0; k < 32; k++) n += m_busy[k] ? 1 : 0;
      return n;
   endfunction

   function automatic void exp_read(input logic [AW-1:0] a, input bit byp,
                                    output logic [DW-1:0] d, output logic b);
      if (reset || a == 0) begin
         d = 0; b = 0;
      end else if (byp && wr1_en && wr1_addr == a) begin
         d = wr1_data; b = 0;
      end else if (byp && wr0_en && wr0_addr == a) begin
         d = wr0_data; b = 0;
      end else begin
         d = m_reg[a]; b = m_busy[a];
      end
   endfunction

   task automatic check_outputs();
      logic [DW-1:0] d;
      logic          b;
      for (int p = 0; p < NR; p++) begin
         exp_read(ra[p], 1'b1, d, b);
         check("rd_data_byp", rd_data_a[p*DW +: DW], d);
         check("rd_busy_byp", {31'b0, rd_busy_a[p]}, {31'b0, b});
         exp_read(ra[p], 1'b0, d, b);
         check("rd_data_nobyp", rd_data_b[p*DW +: DW], d);
         check("rd_busy_nobyp", {31'b0, rd_busy_b[p]}, {31'b0, b});
      end
      check("busy_cnt_byp",   32'(cnt_a), 32'(pending()));
      check("busy_cnt_nobyp", 32'(cnt_b), 32'(pending()));
      check("v0_byp",   v0_a, m_reg[2]);
      check("v0_nobyp", v0_b, m_reg[2]);
   endtask

   task automatic model_update();
      if (reset) begin
         for (int k = 0; k < 32; k++) begin
            m_reg[k] = 0; m_busy[k] = 0;
         end
      end else begin
         if (wr0_en && wr0_addr != 0) begin m_reg[wr0_addr] = wr0_data; m_busy[wr0_addr] = 0; end
         if (wr1_en && wr1_addr != 0) begin m_reg[wr1_addr] = wr1_data; m_busy[wr1_addr] = 0; end
         if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1;
      end
   endtask

   // Inputs are set between posedge and negedge; outputs are checked at the negedge.
   task automatic cycle();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      reset = 0; wr0_en = 0; wr1_en = 0; claim_en = 0;
      wr0_addr = 0; wr1_addr = 0; claim_addr = 0;
      wr0_data = 0; wr1_data = 0;
      ra[0] = 0; ra[1] = 0;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 5));
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset = 1;
      @(posedge clk);
      model_update();
      #1;

      // Reset clears writes and claims
      idle(); wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF; claim_en = 1; claim_addr = 7;
      cycle();
      idle(); reset = 1; ra[0] = 5; ra[1] = 7;
      #1;
      check("rst_high_rd5", rd_data_a[31:0], 32'h0);
      check("rst_high_busy7", {31'b0, rd_busy_a[1]}, 32'h0);
      cycle();
      idle(); ra[0] = 5; ra[1] = 7;
      #1;
      check("rst_rel_r5", rd_data_a[31:0], 32'h0);
      check("rst_rel_busy7", {31'b0, rd_busy_a[1]}, 32'h0);
      check("rst_rel_cnt", 32'(cnt_a), 32'h0);
      check("rst_rel_v0", v0_a, 32'h0);
      cycle();

      // r0 protection
      idle(); wr0_en = 1; wr0_addr = 0; wr0_data = 32'h12345678; claim_en = 1; claim_addr = 0;
      cycle();
      idle();
      #1;
      check("r0_data", rd_data_a[31:0], 32'h0);
      check("r0_cnt", 32'(cnt_a), 32'h0);
      cycle();

      // Dual write collision and split write
      idle(); wr0_en = 1; wr0_addr = 2; wr0_data = 32'h11111111;
      wr1_en = 1; wr1_addr = 2; wr1_data = 32'h22222222;
      cycle();
      idle(); ra[0] = 2;
      #1;
      check("coll_r2", rd_data_b[31:0], 32'h22222222);
      check("coll_v0", v0_b, 32'h22222222);
      cycle();
      idle(); wr0_en = 1; wr0_addr = 3; wr0_data = 32'h33330003;
      wr1_en = 1; wr1_addr = 4; wr1_data = 32'h44440004;
      cycle();
      idle(); ra[0] = 3; ra[1] = 4;
      #1;
      check("split_r3", rd_data_b[31:0], 32'h33330003);
      check("split_r4", rd_data_b[63:32], 32'h44440004);
      cycle();

      // Bypass vs stored read
      idle(); ra[1] = 9; wr0_en = 1; wr0_addr = 9; wr0_data = 32'hCAFEF00D;
      #1;
      check("byp_same", rd_data_a[63:32], 32'hCAFEF00D);
      check("nobyp_same", rd_data_b[63:32], 32'h0);
      cycle();
      idle(); ra[1] = 9;
      #1;
      check("nobyp_next", rd_data_b[63:32], 32'hCAFEF00D);
      cycle();

      // Scoreboard claim/clear
      idle(); claim_en = 1; claim_addr = 8;
      cycle();
      idle(); ra[0] = 8;
      #1;
      check("sb_busy8", {31'b0, rd_busy_a[0]}, 32'h1);
      check("sb_cnt1", 32'(cnt_a), 32'd1);
      claim_en = 1; claim_addr = 10;
      cycle();
      check("sb_cnt2", 32'(cnt_a), 32'd2);
      idle(); wr1_en = 1; wr1_addr = 8; wr1_data = 32'h88;
      cycle();
      check("sb_clr8", 32'(cnt_a), 32'd1);
      idle(); claim_en = 1; claim_addr = 10; wr0_en = 1; wr0_addr = 10; wr0_data = 32'hA0; ra[0] = 10;
      #1;
      check("sb_claim_wr_same", {31'b0, rd_busy_a[0]}, 32'h0);
      cycle();
      idle(); ra[0] = 10;
      #1;
      check("sb_busy10_kept", {31'b0, rd_busy_a[0]}, 32'h1);
      check("sb_cnt_kept", 32'(cnt_a), 32'd1);
      cycle();

      // Full scoreboard
      for (int k = 1; k < 32; k++) begin
         idle(); claim_en = 1; claim_addr = AW'(k); ra[0] = AW'(k);
         cycle();
      end
      check("full_cnt", 32'(cnt_a), 32'd31);
      for (int k = 1; k < 32; k++) begin
         idle();
         if (k % 2 == 1) begin wr0_en = 1; wr0_addr = AW'(k); wr0_data = 32'(k); end
         else            begin wr1_en = 1; wr1_addr = AW'(k); wr1_data = 32'(k); end
         cycle();
      end
      check("empty_cnt", 32'(cnt_a), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 63) == 0);
         wr0_en     = ($urandom_range(0, 1) == 1);
         wr0_addr   = rand_addr();
         wr0_data   = $urandom;
         wr1_en     = ($urandom_range(0, 2) == 0);
         wr1_addr   = rand_addr();
         wr1_data   = $urandom;
         claim_en   = ($urandom_range(0, 1) == 1);
         claim_addr = rand_addr();
         ra[0]      = rand_addr();
         ra[1]      = rand_addr();
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor register file for the pipelined MIPS core.
- Provides NUM_RD combinational read ports and two synchronous write ports (ALU/WB and load/MEM).
- Optional same-cycle write-to-read bypass.
- Per-register scoreboard: issue marks a destination pending; writeback clears it. Hazard logic stalls on busy sources.
- Register 0 is hardwired to zero. A debug tap of $v0 is kept for the testbench.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns stored value only
V0_IDX, 2, index driven on register_v0

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
wr0_en  in  1  write port 0 enable (WB stage)
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (load return)
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
claim_en  in  1  mark claim_addr pending (issue of an instruction with a destination)
claim_addr  in  ADDR_W  destination being claimed
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data
rd_busy  out  NUM_RD  1 = source register i has a pending write
busy_cnt  out  ADDR_W+1  number of pending registers
register_v0  out  DATA_W  stored value of regs[V0_IDX], no bypass

Behaviour:
- Storage:
  - Storage is regs[2**ADDR_W] of DATA_W bits, plus a busy bit vector of the same depth.
  - Reset is synchronous. On a clk edge with reset=1, all regs and all busy bits go to 0 and busy_cnt goes to 0.
  - All writes, claims and clears are ignored during that cycle.
  - While reset=1, rd_data and rd_busy are forced to 0 combinationally. register_v0 shows stored state, which is 0 after the first reset edge.
- Writes (edge, reset=0):
  - wrN_en=1 with wrN_addr!=0 stores wrN_data.
  - Writes to address 0 are dropped.
  - If both ports write the same address, wr1 wins.
  - Different addresses are both written.
- Scoreboard (edge, reset=0):
  - An enabled write to a nonzero address clears that address's busy bit.
  - claim_en=1 with claim_addr!=0 sets the claimed address's busy bit.
  - If a claim and a write hit the same address in the same cycle, the claim wins and the bit stays 1 (new producer).
  - Claiming an address that is already busy leaves it busy. There is no nesting count.
  - Claims to address 0 are ignored. busy[0] is always 0.
- busy_cnt:
  - busy_cnt is a registered population count of the busy bits, updated on the same edge as the busy vector.
  - It is computed from the next-state vector, so it is always consistent with busy.
  - Range is 0..2**ADDR_W-1.
- Reads (combinational, zero latency, reset=0):
  - If rd_addr=0, rd_data=0 and rd_busy=0.
  - If BYPASS=1 and a write to that nonzero address is enabled this cycle, rd_data is the write data (wr1 priority) and rd_busy=0.
  - If that same address is also being claimed this cycle, rd_busy still returns 0 for this cycle; the new claim is visible next cycle.
  - Otherwise rd_data=regs[addr] and rd_busy=busy[addr].
  - If BYPASS=0, rd_data is the stored value and rd_busy is the stored bit; a same-cycle write is visible on the next cycle.
- Outputs contain no X at any time after the first reset edge.

Test Plan:
- Reset:
  - Stimulus: write 0xDEADBEEF to r5 and claim r7, then hold reset=1 for one edge; read r5/r7 with reset high, then again after release.
  - Required: with reset high, rd_data=0 and rd_busy=0. After release, r5=0, busy[7]=0, busy_cnt=0, register_v0=0.
- r0 protection:
  - Stimulus: wr0 writes 0x12345678 to r0; claim r0; read r0.
  - Required: rd_data=0, rd_busy=0, busy_cnt unchanged.
- Dual write collision:
  - Stimulus: wr0 writes 0x11111111 to r2 and wr1 writes 0x22222222 to r2 on the same edge.
  - Required: next cycle r2=0x22222222 and register_v0=0x22222222.
  - Stimulus: wr0 to r3 and wr1 to r4 on the same edge.
  - Required: both values are stored.
- Bypass:
  - Stimulus: BYPASS=1, read port 1 on r9 while wr0 writes 0xCAFEF00D to r9.
  - Required: rd_data=0xCAFEF00D in the same cycle.
  - Stimulus: repeat with BYPASS=0.
  - Required: old value in the same cycle, 0xCAFEF00D on the next cycle.
- Scoreboard:
  - Stimulus: claim r8 → rd_busy=1, busy_cnt=1. Claim r10 → busy_cnt=2. Write r8 → busy_cnt=1.
  - Stimulus: claim r10 and write r10 on the same edge.
  - Required: busy[10] stays 1 and busy_cnt=1.
- Full scoreboard:
  - Stimulus: claim r1..r31 on 31 consecutive cycles.
  - Required: busy_cnt=31.
  - Stimulus: clear them all via alternating wr0/wr1.
  - Required: busy_cnt=0.
